ir_nec_tx: RTL

//  NEC-protocol IR transmit sequencer. Builds the mark/space envelope that gates the 38 kHz carrier PWM

---
 rtl/ir_nec_tx_pkg.sv | 63 ++++++
 rtl/ir_nec_tx_unit_tick.sv | 35 +++
 rtl/ir_nec_tx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ir_nec_tx_pkg.sv
// Shared NEC protocol constants, FSM state encoding and small helpers
// used by the IR transmit sequencer.
package ir_nec_tx_pkg;

  localparam int F_CLK = 100_000_000;

  localparam int HDR_MARK_UNITS   = 16;
  localparam int HDR_SPACE_UNITS  = 8;
  localparam int BIT_MARK_UNITS   = 1;
  localparam int BIT0_SPACE_UNITS = 1;
  localparam int BIT1_SPACE_UNITS = 3;
  localparam int STOP_MARK_UNITS  = 1;
  localparam int RPT_MARK_UNITS   = 16;
  localparam int RPT_SPACE_UNITS  = 4;
  localparam int RPT_STOP_UNITS   = 1;
  localparam int FRAME_BITS       = 32;

  localparam int SEG_W = $clog2(HDR_MARK_UNITS - 1) + 1;
  localparam int BIT_W = $clog2(FRAME_BITS - 1) + 1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_HDR_MARK  = 4'd1,
    ST_HDR_SPACE = 4'd2,
    ST_BIT_MARK  = 4'd3,
    ST_BIT_SPACE = 4'd4,
    ST_STOP_MARK = 4'd5,
    ST_GAP       = 4'd6,
    ST_RPT_MARK  = 4'd7,
    ST_RPT_SPACE = 4'd8,
    ST_RPT_STOP  = 4'd9
  } nec_state_e;

  // Units left after the first one, loaded on segment entry.
  function automatic logic [SEG_W-1:0] seg_units_m1(input nec_state_e st, input logic bit_val);
    int units;
    units = 1;
    case (st)
      ST_HDR_MARK:  units = HDR_MARK_UNITS;
      ST_HDR_SPACE: units = HDR_SPACE_UNITS;
      ST_BIT_MARK:  units = BIT_MARK_UNITS;
      ST_BIT_SPACE: units = bit_val ? BIT1_SPACE_UNITS : BIT0_SPACE_UNITS;
      ST_STOP_MARK: units = STOP_MARK_UNITS;
      ST_RPT_MARK:  units = RPT_MARK_UNITS;
      ST_RPT_SPACE: units = RPT_SPACE_UNITS;
      ST_RPT_STOP:  units = RPT_STOP_UNITS;
      default:      units = 1;
    endcase
    return SEG_W'(units - 1);
  endfunction

  // The repeat stop burst is a mark like the frame stop bit.
  function automatic logic is_mark_state(input nec_state_e st);
    return (st == ST_HDR_MARK) || (st == ST_BIT_MARK) || (st == ST_STOP_MARK) ||
           (st == ST_RPT_MARK) || (st == ST_RPT_STOP);
  endfunction

  function automatic logic [FRAME_BITS-1:0] nec_frame_word(input logic [7:0] addr,
                                                           input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

endpackage

// File: rtl/ir_nec_tx_unit_tick.sv
// Free-running NEC unit timer: one-cycle tick every UNIT_CYCLES clocks,
// restartable so each segment begins on a unit boundary.
module ir_nec_tx_unit_tick #(
  parameter int UNIT_CYCLES = 56_250
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(UNIT_CYCLES - 1) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UNIT_CYCLES - 1);

  logic [CNT_W-1:0] unit_cnt_q;
  logic [CNT_W-1:0] unit_cnt_d;

  always_comb begin
    unit_cnt_d = unit_cnt_q + 1'b1;
    if (clr || (unit_cnt_q == CNT_LAST)) begin
      unit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unit_cnt_q <= '0;
    end else begin
      unit_cnt_q <= unit_cnt_d;
    end
  end

  assign tick = (unit_cnt_q == CNT_LAST);

endmodule

// File: rtl/ir_nec_tx.sv
// NEC IR transmit sequencer: produces the mark/space envelope for one
// frame, followed by repeat codes every frame period while hold is high.
module ir_nec_tx
  import ir_nec_tx_pkg::*;
#(
  parameter int UNIT_CYCLES  = 56_250,
  parameter int FRAME_CYCLES = 10_800_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  input  logic       hold,
  output logic       carrier_en,
  output logic       busy,
  output logic       done
);

  localparam int FRAME_W = $clog2(FRAME_CYCLES - 1) + 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYCLES - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(FRAME_BITS - 1);

  nec_state_e            state_q, state_d;
  logic [SEG_W-1:0]      seg_cnt_q, seg_cnt_d;
  logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                  carrier_en_q, carrier_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic unit_clr;
  logic unit_tick;
  logic seg_end;

  ir_nec_tx_unit_tick #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_unit_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (unit_clr),
    .tick (unit_tick)
  );

  assign seg_end = unit_tick && (seg_cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    seg_cnt_d   = seg_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_cnt_d = (frame_cnt_q != FRAME_LAST) ? frame_cnt_q + 1'b1 : frame_cnt_q;
    unit_clr    = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_HDR_MARK;
          shift_d   = nec_frame_word(addr, cmd);
          bit_idx_d = '0;
        end
      end
      ST_HDR_MARK:  if (seg_end) state_d = ST_HDR_SPACE;
      ST_HDR_SPACE: if (seg_end) state_d = ST_BIT_MARK;
      ST_BIT_MARK:  if (seg_end) state_d = ST_BIT_SPACE;
      ST_BIT_SPACE: begin
        if (seg_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == BIT_LAST) begin
            state_d = ST_STOP_MARK;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            state_d   = ST_BIT_MARK;
          end
        end
      end
      ST_STOP_MARK: if (seg_end) state_d = ST_GAP;
      ST_GAP: begin
        // hold only matters on the final cycle of the frame period.
        if (frame_cnt_q == FRAME_LAST) begin
          if (hold) begin
            state_d = ST_RPT_MARK;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_RPT_MARK:  if (seg_end) state_d = ST_RPT_SPACE;
      ST_RPT_SPACE: if (seg_end) state_d = ST_RPT_STOP;
      ST_RPT_STOP:  if (seg_end) state_d = ST_GAP;
      default:      state_d = ST_IDLE;
    endcase

    // Every segment entry restarts unit timing and reloads its length.
    if (state_d != state_q) begin
      unit_clr  = 1'b1;
      seg_cnt_d = seg_units_m1(state_d, shift_q[0]);
      if ((state_d == ST_HDR_MARK) || (state_d == ST_RPT_MARK)) begin
        frame_cnt_d = '0;
      end
    end else if (unit_tick && (seg_cnt_q != '0)) begin
      seg_cnt_d = seg_cnt_q - 1'b1;
    end

    carrier_en_d = is_mark_state(state_d);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      seg_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      frame_cnt_q  <= '0;
      carrier_en_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      seg_cnt_q    <= seg_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      frame_cnt_q  <= frame_cnt_d;
      carrier_en_q <= carrier_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign carrier_en = carrier_en_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
